// File: rtl/seq_serializer.sv
// Parallel-to-serial converter: a WIDTH-bit word accepted over valid/ready goes out one bit per clock on x.
// Back-to-back words hand off with no gap cycle; hold freezes the shift position.
module seq_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             hold,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             frame_done
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_shift;
   logic             last_go;
   logic             accept;

   // The output end is the MSB when MSB_FIRST, so the register always moves toward it.
   generate
      if (MSB_FIRST) begin : g_msb
         assign sr_shift = {sr_q[WIDTH-2:0], 1'b0};
      end else begin : g_lsb
         assign sr_shift = {1'b0, sr_q[WIDTH-1:1]};
      end
   endgenerate

   assign last_go = (state_q == SHIFT) && (cnt_q == LAST) && !hold;
   assign accept  = din_valid && din_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               sr_d    = din;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (!hold) begin
               if (cnt_q != LAST) begin
                  sr_d  = sr_shift;
                  cnt_d = cnt_q + 1'b1;
               end else if (accept) begin
                  sr_d  = din;
                  cnt_d = '0;
               end else begin
                  state_d = IDLE;
                  sr_d    = '0;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            sr_d    = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      busy       = (state_q == SHIFT);
      x_valid    = busy;
      x          = busy && (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]);
      frame_done = last_go;
      din_ready  = (state_q == IDLE) || last_go;
   end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: an MSB-first and an LSB-first instance share stimulus and are
// compared every cycle against a word/bits-remaining reference model, plus directed stream checks.
module tb_seq_serializer;

   localparam int W = 8;

   logic         clk;
   logic         reset;
   logic [W-1:0] din;
   logic         din_valid;
   logic         hold;
   logic [1:0]   rdy, xo, xv, bsy, fd;

   int n_checks;
   int n_err;

   // reference model: current word and number of its bits still to be shown (0 = idle)
   logic [W-1:0] mw [2];
   int           ml [2];

   // stream capture per instance: bits taken on non-hold valid cycles, valid count, frame_done count
   logic [31:0] cap [2];
   int          nb  [2];
   int          nxv [2];
   int          nfd [2];

   seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (rdy[0]),
      .hold       (hold),
      .x          (xo[0]),
      .x_valid    (xv[0]),
      .busy       (bsy[0]),
      .frame_done (fd[0])
   );

   seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (rdy[1]),
      .hold       (hold),
      .x          (xo[1]),
      .x_valid    (xv[1]),
      .busy       (bsy[1]),
      .frame_done (fd[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_bit(input int i);
      if (ml[i] == 0) return 1'b0;
      // k-th bit out (k = W - ml): MSB-first sends bit W-1-k, LSB-first sends bit k
      return (i == 0) ? mw[i][ml[i]-1] : mw[i][W-ml[i]];
   endfunction

   task automatic check_outputs(input string ph);
      for (int i = 0; i < 2; i++) begin
         logic e_fd, e_rdy;
         e_fd  = (ml[i] == 1) && !hold;
         e_rdy = (ml[i] == 0) || e_fd;
         check($sformatf("%s_x%0d", ph, i),      32'(xo[i]),  32'(model_bit(i)));
         check($sformatf("%s_xvalid%0d", ph, i), 32'(xv[i]),  32'(ml[i] > 0));
         check($sformatf("%s_busy%0d", ph, i),   32'(bsy[i]), 32'(ml[i] > 0));
         check($sformatf("%s_fdone%0d", ph, i),  32'(fd[i]),  32'(e_fd));
         check($sformatf("%s_ready%0d", ph, i),  32'(rdy[i]), 32'(e_rdy));
      end
   endtask

   task automatic clr_cap();
      for (int i = 0; i < 2; i++) begin
         cap[i] = '0;
         nb[i]  = 0;
         nxv[i] = 0;
         nfd[i] = 0;
      end
   endtask

   // one clock: compare at the falling edge, advance the model at the rising edge
   task automatic step(input string ph);
      logic [1:0] acc;
      @(negedge clk);
      if (!reset) begin
         ml[0] = 0;
         ml[1] = 0;
      end
      check_outputs(ph);
      for (int i = 0; i < 2; i++) begin
         if (xv[i]) nxv[i]++;
         if (fd[i]) nfd[i]++;
         if (xv[i] && !hold) begin
            cap[i] = {cap[i][30:0], xo[i]};
            nb[i]++;
         end
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (!reset) begin
            ml[i] = 0;
         end else begin
            acc[i] = din_valid && ((ml[i] == 0) || ((ml[i] == 1) && !hold));
            if (ml[i] > 0 && !hold) ml[i]--;
            if (acc[i]) begin
               mw[i] = din;
               ml[i] = W;
            end
         end
      end
      #1;
   endtask

   task automatic steps(input string ph, input int n);
      for (int k = 0; k < n; k++) step(ph);
   endtask

   task automatic send(input string ph, input logic [W-1:0] d);
      din       = d;
      din_valid = 1'b1;
      step(ph);
      din_valid = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_err     = 0;
      reset     = 1'b0;
      din       = '0;
      din_valid = 1'b0;
      hold      = 1'b0;
      ml[0] = 0; ml[1] = 0;
      mw[0] = '0; mw[1] = '0;
      clr_cap();

      // reset state, with hold and din_valid active to show both are ignored under reset
      din_valid = 1'b1;
      din       = 8'hC3;
      hold      = 1'b1;
      steps("rst", 2);
      din_valid = 1'b0;
      hold      = 1'b0;
      reset     = 1'b1;
      steps("idle", 2);

      // single word 0x66
      clr_cap();
      send("single", 8'h66);
      steps("single", 10);
      check("single_msb_bits", cap[0][7:0], 32'h66);
      check("single_lsb_bits", cap[1][7:0], 32'h66);
      check("single_len", 32'(nxv[0]), 32'd8);
      check("single_fdone_cnt", 32'(nfd[0]), 32'd1);

      // LSB-first word 0x06
      clr_cap();
      send("lsb", 8'h06);
      steps("lsb", 9);
      check("lsb_bits", cap[1][7:0], 32'h60);
      check("lsb_msbinst_bits", cap[0][7:0], 32'h06);

      // back-to-back 0x66 then 0xF0 with din_valid held high
      clr_cap();
      din       = 8'h66;
      din_valid = 1'b1;
      step("b2b");
      steps("b2b", 7);
      din = 8'hF0;
      step("b2b");
      din_valid = 1'b0;
      steps("b2b", 10);
      check("b2b_bits", cap[0][15:0], 32'h66F0);
      check("b2b_len", 32'(nxv[0]), 32'd16);
      check("b2b_fdone_cnt", 32'(nfd[0]), 32'd2);

      // hold three cycles while bit index 2 is on x
      clr_cap();
      send("hold", 8'hA5);
      steps("hold", 2);
      hold = 1'b1;
      steps("hold", 3);
      hold = 1'b0;
      steps("hold", 8);
      check("hold_bits", cap[0][7:0], 32'hA5);
      check("hold_len", 32'(nxv[0]), 32'd11);
      check("hold_nbits", 32'(nb[0]), 32'd8);

      // hold on the last bit with the next word already offered
      clr_cap();
      send("lasthold", 8'h81);
      steps("lasthold", 7);
      din       = 8'h5A;
      din_valid = 1'b1;
      hold      = 1'b1;
      steps("lasthold", 2);
      hold = 1'b0;
      step("lasthold");
      din_valid = 1'b0;
      steps("lasthold", 10);
      check("lasthold_bits", cap[0][15:0], 32'h815A);
      check("lasthold_len", 32'(nxv[0]), 32'd18);

      // reset mid-word after four bits of 0xFF
      clr_cap();
      send("midrst", 8'hFF);
      steps("midrst", 4);
      reset = 1'b0;
      #1;
      ml[0] = 0;
      ml[1] = 0;
      check("midrst_x", 32'(xo), 32'd0);
      check("midrst_xvalid", 32'(xv), 32'd0);
      check("midrst_ready", 32'(rdy), 32'd3);
      steps("midrst", 2);
      reset = 1'b1;
      steps("postrst", 5);
      check("postrst_len", 32'(nxv[0]), 32'd4);

      // din_valid pulse while shifting at cnt=3 is ignored
      clr_cap();
      send("ign", 8'h3C);
      steps("ign", 3);
      din       = 8'hAA;
      din_valid = 1'b1;
      step("ign");
      din_valid = 1'b0;
      steps("ign", 8);
      check("ign_bits", cap[0][7:0], 32'h3C);
      check("ign_len", 32'(nxv[0]), 32'd8);

      // randomized traffic with occasional reset pulses
      for (int c = 0; c < 3000; c++) begin
         din       = W'($urandom);
         din_valid = ($urandom_range(0, 9) < 7);
         hold      = ($urandom_range(0, 9) < 2);
         reset     = ($urandom_range(0, 149) != 0);
         step("rand");
      end
      reset     = 1'b1;
      din_valid = 1'b0;
      hold      = 1'b0;
      steps("drain", 12);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
